// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC responder model.
package adc_pkg;

  localparam int ADC_DATA_W  = 10;
  localparam int ADC_N_CH    = 4;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CONFIG,
    ST_SAMPLE,
    ST_NULL,
    ST_DATA,
    ST_TAIL
  } adc_state_t;

  // Command captured after the start bit, MSB first: SGL/DIFF, D1, D0.
  typedef struct packed {
    logic       sgl;
    logic [1:0] ch;
  } adc_cmd_t;

endpackage

// File: rtl/adc_spi_responder_pin_sync_edge.sv
// Pin synchroniser (SYNC_STAGES flops) followed by an edge register.
// o_rise/o_fall are combinational off the last two flops, so the FSM
// acting on them lands three i_clk edges after the pin moved.
module pin_sync_edge
  import adc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchroniser, keep one delayed copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = sync_q[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~prev_q;
  assign o_fall = ~o_lvl & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Pin-level model of a 4-channel 10-bit SPI ADC (start bit, SGL/DIFF,
// D1, D0; then null bit and D9..D0 on DOUT). Oversamples SCLK/CS/DIN
// on i_clk, which must run at >= 8x SCLK.
// Build option: ADC_RESP_LSB_REPEAT_EN -- after D0, repeat the sample
// LSB-first (D1..D9) before falling back to zeros.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int N_CH   = ADC_N_CH
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         p_clk,
  input  logic                         p_cs,
  input  logic                         p_in,
  output logic                         p_out,
  output logic                         p_out_oe,
  input  logic [N_CH-1:0][DATA_W-1:0]  i_samples,
  output logic [DATA_W-1:0]            o_sample,
  output logic [1:0]                   o_channel,
  output logic                         o_conv_done,
  output logic                         o_frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_lvl, cs_rise_unused, cs_fall_unused;
  logic din_lvl, din_rise_unused, din_fall_unused;

  pin_sync_edge u_sync_sclk (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_clk),
                             .o_lvl(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall));
  pin_sync_edge u_sync_cs   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_cs),
                             .o_lvl(cs_lvl), .o_rise(cs_rise_unused), .o_fall(cs_fall_unused));
  pin_sync_edge u_sync_din  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_in),
                             .o_lvl(din_lvl), .o_rise(din_rise_unused), .o_fall(din_fall_unused));

  adc_state_t        state;
  adc_cmd_t          cmd_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              cs_armed;  // CS seen high since reset/last frame

  logic [DATA_W-1:0] in_p, in_n, conv;
  logic [DATA_W:0]   diff;

  // Conversion result: single-ended pick, or IN+ - IN- clamped at zero.
  always_comb begin
    in_p = i_samples[cmd_q.ch];
    in_n = i_samples[{cmd_q.ch[1], ~cmd_q.ch[0]}];
    diff = {1'b0, in_p} - {1'b0, in_n};
    if (cmd_q.sgl)          conv = in_p;
    else if (diff[DATA_W])  conv = '0;
    else                    conv = diff[DATA_W-1:0];
  end

  // Frame FSM; CS high overrides any SCLK edge seen in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      cs_armed    <= 1'b0;
      p_out       <= 1'b0;
      p_out_oe    <= 1'b0;
      o_sample    <= '0;
      o_channel   <= '0;
      o_conv_done <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_conv_done <= 1'b0;
      o_frame_err <= 1'b0;
      if (cs_lvl) begin
        if (state inside {ST_CONFIG, ST_SAMPLE, ST_NULL, ST_DATA})
          o_frame_err <= 1'b1;
        state    <= ST_IDLE;
        cs_armed <= 1'b1;
        p_out    <= 1'b0;
        p_out_oe <= 1'b0;
        shreg    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Only a CS low that follows a CS high opens a frame.
            if (cs_armed) begin
              cs_armed <= 1'b0;
              state    <= ST_WAIT_START;
            end
          end
          ST_WAIT_START: begin
            if (sclk_rise && din_lvl) begin
              bit_cnt <= '0;
              state   <= ST_CONFIG;
            end
          end
          ST_CONFIG: begin
            if (sclk_rise) begin
              cmd_q   <= adc_cmd_t'({cmd_q.ch, din_lvl});
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(2)) state <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            if (sclk_fall) begin
              shreg     <= conv;
              o_sample  <= conv;
              o_channel <= cmd_q.ch;
              p_out_oe  <= 1'b1;
              p_out     <= 1'b0;
              state     <= ST_NULL;
            end
          end
          ST_NULL: begin
            if (sclk_fall) begin
              p_out   <= shreg[DATA_W-1];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= CNT_W'(1);
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              p_out   <= shreg[DATA_W-1];
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                o_conv_done <= 1'b1;
                state       <= ST_TAIL;
`ifdef ADC_RESP_LSB_REPEAT_EN
                // D0 is shared; the repeat starts at D1.
                shreg <= {1'b0, o_sample[DATA_W-1:1]};
`endif
              end
            end
          end
          ST_TAIL: begin
            if (sclk_fall) begin
`ifdef ADC_RESP_LSB_REPEAT_EN
              p_out <= shreg[0];
              shreg <= {1'b0, shreg[DATA_W-1:1]};
`else
              p_out <= 1'b0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI pins at 1/10 of i_clk
// and checks DOUT bit streams and status outputs.
module tb_adc_spi_responder;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              p_clk, p_cs, p_in;
  logic              p_out, p_out_oe;
  logic [3:0][9:0]   i_samples;
  logic [9:0]        o_sample;
  logic [1:0]        o_channel;
  logic              o_conv_done, o_frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_ferr  = 0;
  int done0, ferr0;

  logic       rx [0:31];
  logic       dummy, seen_oe;
  logic [9:0] word, tail, exp_tail;

  adc_spi_responder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .p_clk(p_clk), .p_cs(p_cs), .p_in(p_in),
    .p_out(p_out), .p_out_oe(p_out_oe), .i_samples(i_samples),
    .o_sample(o_sample), .o_channel(o_channel),
    .o_conv_done(o_conv_done), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_conv_done) n_done++;
    if (o_frame_err) n_ferr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCLK period: DIN set while low, DOUT sampled just before the rise.
  task automatic sclk(input logic din, output logic dout);
    p_in = din;
    #50;
    dout = p_out;
    p_clk = 1'b1;
    #50;
    p_clk = 1'b0;
  endtask

  // CS low, optional leading zeros, start+command, then nrd read cycles.
  // rx[0] is the null bit, rx[1..10] are D9..D0, rx[11..] the tail.
  task automatic frame(input logic sgl, input logic [1:0] ch, input int lead, input int nrd);
    logic [3:0] cmd;
    logic       b;
    cmd = {1'b1, sgl, ch};
    p_cs = 1'b0;
    #100;
    for (int i = 0; i < lead; i++) sclk(1'b0, b);
    for (int i = 3; i >= 0; i--) sclk(cmd[i], b);
    for (int i = 0; i < nrd; i++) begin
      sclk(1'b0, b);
      rx[i] = b;
    end
  endtask

  task automatic cs_high();
    #50;
    p_cs = 1'b1;
    #100;
  endtask

  task automatic get_word();
    word = '0;
    for (int i = 1; i <= 10; i++) word = {word[8:0], rx[i]};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_samples = {10'h155, 10'h2A5, 10'd100, 10'd300};
    i_rst_n = 1'b0; p_cs = 1'b1; p_clk = 1'b0; p_in = 1'b0;
    #2;
    chk("rst_p_out", p_out, 0);
    chk("rst_oe", p_out_oe, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_channel", o_channel, 0);
    chk("rst_pulses", {o_conv_done, o_frame_err}, 0);
    #20 i_rst_n = 1'b1;
    #100;

    // Single-ended ch2 with 10 tail clocks.
    done0 = n_done; ferr0 = n_ferr;
    frame(1'b1, 2'd2, 0, 21);
    chk("se_null", rx[0], 0);
    get_word();
    chk("se_data", word, 10'h2A5);
    tail = '0;
    for (int i = 11; i <= 20; i++) tail = {tail[8:0], rx[i]};
`ifdef ADC_RESP_LSB_REPEAT_EN
    exp_tail = 10'b0100101010;
`else
    exp_tail = 10'b0000000000;
`endif
    chk("se_tail", tail, exp_tail);
    chk("se_oe_hi", p_out_oe, 1);
    chk("se_sample", o_sample, 10'h2A5);
    chk("se_channel", o_channel, 2);
    cs_high();
    chk("se_oe_lo", p_out_oe, 0);
    chk("se_done_cnt", n_done - done0, 1);
    chk("se_no_ferr", n_ferr - ferr0, 0);

    // Pseudo-differential ch0-ch1 = 300-100.
    frame(1'b0, 2'd0, 0, 11);
    get_word();
    chk("diff00_data", word, 10'd200);
    chk("diff00_sample", o_sample, 10'd200);
    chk("diff00_channel", o_channel, 0);
    cs_high();

    // Pseudo-differential ch1-ch0 = 100-300 clamps to zero.
    frame(1'b0, 2'd1, 0, 11);
    get_word();
    chk("diff01_data", word, 0);
    chk("diff01_sample", o_sample, 0);
    chk("diff01_channel", o_channel, 1);
    cs_high();

    // Leading zeros before the start bit.
    frame(1'b1, 2'd2, 3, 11);
    chk("lead_null", rx[0], 0);
    get_word();
    chk("lead_data", word, 10'h2A5);
    cs_high();

    // Abort after D5 has been driven; ch3 = 0x155.
    done0 = n_done; ferr0 = n_ferr;
    frame(1'b1, 2'd3, 0, 5);
    chk("abort_d9_d6", {rx[1], rx[2], rx[3], rx[4]}, 4'b0101);
    #20;
    chk("abort_oe_before", p_out_oe, 1);
    #30 p_cs = 1'b1;
    #30;
    chk("abort_oe_3cyc", p_out_oe, 0);
    #100;
    chk("abort_ferr_cnt", n_ferr - ferr0, 1);
    chk("abort_no_done", n_done - done0, 0);
    chk("abort_sample", o_sample, 10'h155);
    chk("abort_channel", o_channel, 3);

    // Asynchronous reset in the middle of DATA.
    frame(1'b1, 2'd2, 0, 4);
    #20;
    chk("arst_oe_before", p_out_oe, 1);
    i_rst_n = 1'b0;
    #1;
    chk("arst_oe", p_out_oe, 0);
    chk("arst_p_out", p_out, 0);
    chk("arst_sample", o_sample, 0);
    chk("arst_channel", o_channel, 0);
    chk("arst_pulses", {o_conv_done, o_frame_err}, 0);
    #19 i_rst_n = 1'b1;
    done0 = n_done;
    seen_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sclk((i < 4) ? 1'b1 : 1'b0, dummy);
      seen_oe = seen_oe | p_out_oe | dummy;
    end
    chk("arst_silent", seen_oe, 0);
    chk("arst_no_done", n_done - done0, 0);
    cs_high();
    frame(1'b1, 2'd2, 0, 11);
    get_word();
    chk("arst_fresh_data", word, 10'h2A5);
    chk("arst_fresh_channel", o_channel, 2);
    cs_high();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable model of the 4-channel, 10-bit serial ADC device that sits on the far side of the oscilloscope's ADC pins. It oversamples the pin-level SPI signals (`p_clk`, `p_cs`, `p_in`) on the system clock, decodes the start/config command, and shifts the selected 10-bit sample out on `p_out`. It is used in closed-loop simulation and on-board loopback tests in place of the real converter, so the capture path can be exercised without analog hardware.

## Interface
- `DATA_W`, default 10: sample width.
- `N_CH`, default 4: number of channels; the channel select field is 2 bits.
- `i_clk`  in  1: system clock; must run at 8× the SCLK rate or faster.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `p_clk`  in  1: SCLK from the initiator; asynchronous to `i_clk`.
- `p_cs`  in  1: chip select, active-low; asynchronous.
- `p_in`  in  1: DIN (command bits from the initiator); asynchronous.
- `p_out`  out  1: DOUT (data to the initiator).
- `p_out_oe`  out  1: high while the device actively drives DOUT.
- `i_samples`  in  N_CH×DATA_W: analog stand-in values, one per channel.
- `o_sample`  out  DATA_W: last converted value.
- `o_channel`  out  2: last selected channel.
- `o_conv_done`  out  1: one-cycle pulse when D0 has been driven.
- `o_frame_err`  out  1: one-cycle pulse when CS rises mid-frame.

## Operation
- **Input synchronisation.** `p_clk`, `p_cs` and `p_in` each pass through a 2-FF synchroniser, then a registered copy for edge detection.
  - rise = SCLK 0→1.
  - fall = SCLK 1→0.
- **FSM states:** IDLE, WAIT_START, CONFIG, SAMPLE, NULL, DATA, TAIL.
- **IDLE:** CS high. `p_out_oe`=0, `p_out`=0. CS low → WAIT_START.
- **WAIT_START:** on each rise, sample DIN. A 0 is ignored. A 1 is the start bit → CONFIG, with the bit counter cleared.
- **CONFIG:** capture 3 bits on successive rises, in order SGL/DIFF, D1, D0. After the third bit → SAMPLE.
- **SAMPLE:** on the next fall:
  - latch the conversion result into the shift register, `o_sample` and `o_channel`;
  - set `p_out_oe`=1 and drive the null bit (`p_out`=0);
  - go to NULL.
- **NULL:** on the next fall, drive D9 (MSB) → DATA.
- **DATA:** on each fall, shift out the next bit, down to D0.
  - When D0 is driven: pulse `o_conv_done` and go to TAIL.
- **TAIL:** behaviour is set by the macro (see Configuration). The state persists until CS rises.
- **Conversion arithmetic:**
  - SGL=1: result = `i_samples[{D1,D0}]`.
  - SGL=0 (pseudo-differential): IN+ = ch{D1,D0}, IN− = ch{D1,~D0}. Compute IN+ − IN− at DATA_W+1 bits; a negative result clamps to 0. No wrap.
- **CS high from any state** → IDLE, `p_out_oe`=0.
  - If the prior state was CONFIG, SAMPLE, NULL or DATA: pulse `o_frame_err`.
  - The shift register is discarded; `o_sample` and `o_channel` keep their last values.
- **Simultaneous CS rise and SCLK edge:** CS wins; the edge is ignored.
- **Clock edges during IDLE** are ignored.

## Timing
- Pin-to-action latency is 3 `i_clk` cycles from any pin transition (2 synchroniser stages + 1 edge register).
- `p_out` is registered and updates 3 cycles after the SCLK fall. This is valid for the initiator's next rise provided `i_clk` ≥ 8× SCLK.
- `p_out_oe` rises with the null bit and falls 3 cycles after CS rises.
- **Reset values:** `p_out`=0, `p_out_oe`=0, `o_sample`=0, `o_channel`=0, `o_conv_done`=0, `o_frame_err`=0, FSM=IDLE.
- **Reset mid-frame:** the response is immediate (asynchronous). After reset release with CS still low, the block waits in IDLE until CS goes high and then low again.
- **Back-to-back frames:** CS high for ≥4 `i_clk` cycles is guaranteed to be recognised.

## Configuration
- Macro: `ADC_RESP_LSB_REPEAT_EN`.
- **Defined:** in TAIL, successive falls drive D1, D2 … D9 (LSB-first repeat, sharing D0), then 0s.
- **Undefined:** TAIL drives 0 on every fall.
- `o_conv_done` timing is identical in both builds.

## Structure
- Package `adc_pkg` holds:
  - the FSM state enum;
  - `ADC_DATA_W`=10, `ADC_N_CH`=4, `SYNC_STAGES`=2;
  - the `adc_cmd_t` struct {sgl, ch[1:0]}.
- Sub-module `pin_sync_edge`: 2-FF synchroniser plus rise/fall detector, instantiated three times (fall output unused for CS/DIN).

## Test plan
- **Single-ended read.** `i_samples[2]`=0x2A5; DIN = 1,1,1,0 → `p_out` sequence after config: 0, then 1010100101. `o_sample`=0x2A5, `o_channel`=2, one `o_conv_done` pulse.
- **Pseudo-differential read.**
  - ch0=300, ch1=100, SGL=0, D1D0=00 → 200.
  - Same inputs, D1D0=01 → 0 (clamped).
- **Leading zeros.** Three 0 bits on DIN before the start bit → decode unaffected; result still 0x2A5 for ch2.
- **Abort.** CS rises after D5 is driven → one `o_frame_err` pulse, no `o_conv_done`, `p_out_oe`=0 within 3 cycles, `o_sample` shows the new latched value.
- **Tail behaviour.** Clock 10 extra SCLKs after D0 with value 0x2A5 → with the macro: 0,1,0,0,1,0,1,0,1 then 0. Without it: all 0.
- **Async reset mid-DATA.** All outputs are at reset values the same cycle. With CS held low, no response until a fresh CS cycle.
